mux8_arbiter: RTL

MUX8_ARBITER -- requirements
Module: mux8_arbiter

---
 rtl/mux8_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mux8_arbiter.sv
// Round-robin packet arbiter for an 8:1 mux. A grant holds until the packet's
// last beat transfers, or until the granted requester stays idle for TIMEOUT cycles.
module mux8_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       out_valid,
  output logic       out_last,
  output logic       abort,
  output logic       busy
);

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            abort_q, abort_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [SW-1:0]   win_c;
  logic [SW-1:0]   idx_c;
  logic            found_c;
  logic            req_sel_c;

  // First requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    win_c   = ptr_q;
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx_c = ptr_q + SW'(i);
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  assign req_sel_c = req[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    abort_d = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        cnt_d = '0;
        if (found_c) begin
          state_d       = GRANT;
          sel_d         = win_c;
          gnt_d[win_c]  = 1'b1;
        end
      end

      GRANT: begin
        if (req_sel_c) begin
          cnt_d = '0;
          if (out_ready && last[sel_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = sel_q + SW'(1);
          end
        end else if (cnt_q == CNT_LAST) begin
          // Granted requester went quiet too long: drop the lock and move on.
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SW'(1);
          cnt_d   = '0;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign abort     = abort_q;
  assign busy      = (state_q == GRANT);
  assign out_valid = busy && req_sel_c;
  assign out_last  = out_valid && last[sel_q];

endmodule
